// File: rtl/mul_unit_if.sv
// mul_unit_if: operand/request and write-back/flag bundle between regfile stage and mul_unit.
interface mul_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             accumulate;
  logic             setflags;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_acc;
  logic [3:0]       wa_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       wa_out;
  logic             we_out;
  logic             flag_we;
  logic             n_flag;
  logic             z_flag;
  modport master (
    output start, accumulate, setflags, op_a, op_b, op_acc, wa_in,
    input  busy, done, result, wa_out, we_out, flag_we, n_flag, z_flag
  );
  modport slave (
    input  start, accumulate, setflags, op_a, op_b, op_acc, wa_in,
    output busy, done, result, wa_out, we_out, flag_we, n_flag, z_flag
  );
endinterface

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add MUL/MLA producing regfile write-back and N/Z flag updates.
module mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  mul_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, result_q;
  logic [CNTW-1:0]  cnt_q;
  logic [3:0]       wa_q;
  logic             sf_q, r15_q, busy_q, done_q, we_q, flag_we_q;
  logic [WIDTH-1:0] sum_d;
  logic             last_d, accept_d;
  always_comb begin
    sum_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
    last_d   = (mplier_q >> 1) == '0 || cnt_q == CNTW'(WIDTH - 1);
    accept_d = bus.start && state_q != RUN;
  end
  // Write-back and flag pulses are raised on the final RUN edge so they are valid for the whole DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      wa_q      <= '0;
      sf_q      <= 1'b0;
      r15_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      flag_we_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      flag_we_q <= 1'b0;
      if (accept_d) begin
        acc_q    <= bus.accumulate ? bus.op_acc : '0;
        mcand_q  <= bus.op_a;
        mplier_q <= bus.op_b;
        cnt_q    <= '0;
        wa_q     <= bus.wa_in;
        sf_q     <= bus.setflags;
        r15_q    <= bus.wa_in == 4'd15;
        busy_q   <= 1'b1;
        state_q  <= RUN;
      end else if (state_q == RUN) begin
        acc_q    <= sum_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNTW'(1);
        if (last_d) begin
          result_q  <= sum_d;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          we_q      <= !r15_q;
          flag_we_q <= sf_q;
          state_q   <= DONE;
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end
  // wa_out follows the result so both stay stable through a following RUN.
  logic [3:0] wa_out_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wa_out_q <= '0;
    else if (state_q == RUN && last_d) wa_out_q <= wa_q;
  end
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.wa_out  = wa_out_q;
  assign bus.we_out  = we_q;
  assign bus.flag_we = flag_we_q;
  assign bus.n_flag  = result_q[WIDTH-1];
  assign bus.z_flag  = result_q == '0;
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
Iterative shift-add multiply/multiply-accumulate unit for the ARM datapath. It sits directly downstream of the register file. It consumes Rm (rd1), Rs (rs port) and Rn (rd2) for MUL/MLA, and produces a write-back value, destination and write enable that drive the register file write port (wd3/wa3/we3). It also produces N/Z flag updates for the S-bit.

Parameters:
WIDTH, 32, operand/result width in bits
CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled on rising edge of clk
accumulate  input  1  1 = MLA (add op_acc), 0 = MUL
setflags  input  1  S-bit; request N/Z update
op_a  input  WIDTH  multiplicand (Rm, from rd1)
op_b  input  WIDTH  multiplier (Rs, from rs)
op_acc  input  WIDTH  accumulate addend (Rn, from rd2)
wa_in  input  4  destination register number
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle completion pulse
result  output  WIDTH  product/sum, low WIDTH bits
wa_out  output  4  latched destination (to regfile wa3)
we_out  output  1  regfile write enable pulse (to we3)
flag_we  output  1  N/Z update pulse
n_flag  output  1  result[WIDTH-1]
z_flag  output  1  result == 0

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; busy, done, we_out, flag_we = 0; result, wa_out, internal accumulator/multiplicand/multiplier/counter = 0; n_flag=0; z_flag=1 (derived from result=0).
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted only when state is IDLE or DONE.
  - On acceptance: acc <= accumulate ? op_acc : 0; mcand <= op_a; mplier <= op_b; cnt <= 0.
  - wa_in, setflags and the wa_in==15 condition are latched.
  - state <= RUN.
- start while in RUN: ignored; operands are not sampled.
- RUN, per cycle:
  - if mplier[0], acc <= acc + mcand, modulo 2^WIDTH.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt+1.
  - Exit to DONE when (mplier >> 1) == 0 or cnt == WIDTH-1.
  - RUN therefore lasts k = max(1, position of highest set bit of op_b + 1) cycles. k=1 for op_b=0; k=WIDTH maximum.
- Timing: with start accepted at edge T, the last RUN edge is T+k.
  - done is high in the cycle following T+k, for exactly one cycle.
  - In that cycle result equals the final acc. The final acc update and the transfer into result occur on the same edge T+k.
- busy: high exactly while state==RUN.
- DONE:
  - done=1.
  - we_out=1 unless latched wa==15; r15 is never written by this unit.
  - flag_we = latched setflags.
  - Next state is RUN if start is asserted, else IDLE. This allows back-to-back issue with a single bubble.
- result, wa_out, n_flag and z_flag hold stable from DONE until the next DONE. They do not change during a following RUN.
- Arithmetic: unsigned shift-add. The low WIDTH bits are identical for signed operands. Overflow bits are discarded; C and V are not produced.
- reset_n asserted mid-RUN: the operation is abandoned immediately and all outputs take their reset values. No write pulse is issued.

Test Plan:
1. MUL, op_a=7, op_b=6, wa_in=3, start one cycle -> busy high for 3 cycles; done, we_out pulse in the 4th cycle after the start edge; result=42, wa_out=3, flag_we=0.
2. MLA, op_a=0xFFFFFFFF, op_b=2, op_acc=5, setflags=1 -> k=2; result=0x00000003; n_flag=0, z_flag=0, flag_we=1.
3. MUL, op_b=0, op_a=0x1234, setflags=1 -> k=1; result=0, z_flag=1, flag_we pulses.
4. MUL, op_a=0x80000000, op_b=0xFFFFFFFF -> k=32; done on the 33rd cycle; result=0x80000000, n_flag=1.
5. During RUN of case 4, assert start with op_a=1, op_b=1 -> ignored; result still 0x80000000.
   - Then repeat case 4 and drop reset_n at RUN cycle 10 -> busy=0, result=0 immediately; no done or we_out pulse.
6. wa_in=15, op_a=3, op_b=3 -> done pulses with result=9, we_out stays 0.
   - Start asserted in that DONE cycle with op_a=2, op_b=2 -> accepted; result=4 after k=2.
